sdes_core: RTL and testbench
============================

SDES_CORE -- requirements
Module: sdes_core

Interface
REQ-001 SHALL have parameter NUM_ROUNDS, default 2, meaning Feistel round count; legal range 2..16.
REQ-002 SHALL have port clk  input  1  sole clock, rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port in_valid  input  1  request present.
REQ-005 SHALL have port in_ready  output  1  core can accept a request.
REQ-006 SHALL have port in_mode  input  1  0 = encrypt, 1 = decrypt.
REQ-007 SHALL have port in_key  input  10  S-DES key; bit 9 is key bit 1.
REQ-008 SHALL have port in_data  input  8  plaintext or ciphertext; bit 7 is bit 1.
REQ-009 SHALL have port out_valid  output  1  result present.
REQ-010 SHALL have port out_ready  input  1  consumer accepts result.
REQ-011 SHALL have port out_data  output  8  result block.
REQ-012 SHALL have port busy  output  1  high in ROUND or DONE.

Function
REQ-013 SHALL implement FSM states IDLE, ROUND and DONE.
REQ-014 SHALL drive in_ready high only in IDLE.
REQ-015 SHALL accept a request on an edge with in_valid and in_ready both high, and SHALL then register the following:
- IP(in_data);
- in_mode;
- all NUM_ROUNDS subkeys.
It SHALL clear the round counter and enter ROUND.
REQ-016 Subkey generation SHALL be:
- the key passes through P10 and is split into two 5-bit halves;
- before subkey i, each half is rotated left by 1 for i=1 and by 2 for i>1, cumulatively mod 5;
- subkey i = P8 of the rotated halves.
For NUM_ROUNDS=2 this gives standard S-DES K1 and K2.
REQ-017 Each ROUND cycle SHALL apply one fk:
- L' = L xor P4(S0||S1 of EP(R) xor subkey);
- R unchanged;
- then swap halves, except after the final round.
REQ-018 Subkey index in round r (0-based) SHALL be r for encrypt and NUM_ROUNDS-1-r for decrypt.
REQ-019 After NUM_ROUNDS ROUND cycles the core SHALL enter DONE and set out_valid=1 with out_data = IIP(state), so out_valid rises exactly NUM_ROUNDS+1 edges after the accepting edge.
REQ-020 While out_valid=1 and out_ready=0, out_data SHALL hold stable.
REQ-021 On an edge with out_valid=1 and out_ready=1, the core SHALL clear out_valid and return to IDLE; the earliest next acceptance is the following edge.
REQ-022 in_valid outside IDLE SHALL be ignored, with no state change.
REQ-023 out_data SHALL retain its last value when out_valid=0.
REQ-024 The round counter SHALL be ceil(log2(NUM_ROUNDS+1)) bits wide and SHALL never wrap during a block.

Reset
REQ-025 When rst_n=0 at a clock edge, the core SHALL force all of the following, regardless of state:
- state=IDLE;
- out_valid=0, out_data=8'h00;
- busy=0;
- round counter=0;
- subkey registers=0.
REQ-026 Reset mid-operation SHALL abort the block with no output produced.
REQ-027 in_ready SHALL be 0 during any cycle with rst_n=0 and SHALL be 1 on the first edge after release.

Configuration
REQ-028 Macro SDES_CORE_DECRYPT_EN defined: in_mode SHALL be honoured as in REQ-018.
REQ-029 Macro SDES_CORE_DECRYPT_EN undefined: in_mode SHALL be ignored, the core SHALL always encrypt, and no reverse subkey indexing logic SHALL be present.

Structure
REQ-030 Package sdes_pkg SHALL hold the following:
- P10, P8, IP, IIP, EP and P4 permutation functions;
- S0 and S1 lookup tables;
- the state enum (IDLE, ROUND, DONE);
- the mode enum (ENC=0, DEC=1).
REQ-031 sdes_core SHALL instantiate one combinational sub-module, sdes_round, with the following ports:
- inputs: state[7:0], subkey[7:0], last;
- output: next[7:0].
It performs fk and the conditional swap.

Verification
REQ-032 Encrypt, NUM_ROUNDS=2: key=10'b1010000010, data=8'b10010111, mode=0 -> subkeys 10100100/01000011; out_data=8'b00111000; out_valid 3 edges after acceptance.
REQ-033 Decrypt with macro defined: same key, data=8'b00111000, mode=1 -> out_data=8'b10010111.
REQ-034 Backpressure: out_ready held 0 for 5 cycles after out_valid -> out_valid=1, out_data constant, in_ready=0, and a concurrent in_valid is ignored; out_ready=1 -> IDLE next edge.
REQ-035 Reset mid-block: rst_n=0 during the 2nd ROUND cycle -> next edge out_valid=0, out_data=8'h00, busy=0; a fresh request then completes correctly.
REQ-036 NUM_ROUNDS=4 and NUM_ROUNDS=7: 256 random key/data pairs encrypted then decrypted -> plaintext recovered and results match the reference model; out_valid NUM_ROUNDS+1 edges after acceptance.
REQ-037 Macro undefined: mode=1, key=10'b1010000010, data=8'b10010111 -> out_data=8'b00111000.

Source files
------------

// File: rtl/sdes_pkg.sv
// Shared S-DES definitions: permutations, S-boxes and the FSM/mode encodings.
package sdes_pkg;

    typedef enum logic [1:0] {IDLE, ROUND, DONE} state_e;
    typedef enum logic {ENC = 1'b0, DEC = 1'b1} mode_e;

    // Entry index {row,col}, row = outer bits, col = inner bits
    localparam logic [31:0] S0_T = {
        2'd2, 2'd3, 2'd1, 2'd3, 2'd3, 2'd1, 2'd2, 2'd0,
        2'd0, 2'd1, 2'd2, 2'd3, 2'd2, 2'd3, 2'd0, 2'd1
    };
    localparam logic [31:0] S1_T = {
        2'd3, 2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd0, 2'd3,
        2'd3, 2'd1, 2'd0, 2'd2, 2'd3, 2'd2, 2'd1, 2'd0
    };

    function automatic logic [9:0] p10(input logic [9:0] k);
        return {k[7], k[5], k[8], k[3], k[6], k[0], k[9], k[1], k[2], k[4]};
    endfunction

    function automatic logic [7:0] p8(input logic [9:0] x);
        return {x[4], x[7], x[3], x[6], x[2], x[5], x[0], x[1]};
    endfunction

    function automatic logic [7:0] ip(input logic [7:0] d);
        return {d[6], d[2], d[5], d[7], d[4], d[0], d[3], d[1]};
    endfunction

    function automatic logic [7:0] iip(input logic [7:0] d);
        return {d[4], d[7], d[5], d[3], d[1], d[6], d[0], d[2]};
    endfunction

    function automatic logic [7:0] ep(input logic [3:0] r);
        return {r[0], r[3], r[2], r[1], r[2], r[1], r[0], r[3]};
    endfunction

    function automatic logic [3:0] p4(input logic [3:0] x);
        return {x[2], x[0], x[1], x[3]};
    endfunction

    function automatic logic [1:0] s0(input logic [3:0] x);
        logic [3:0] idx;
        idx = {x[3], x[0], x[2], x[1]};
        return S0_T[{idx, 1'b0} +: 2];
    endfunction

    function automatic logic [1:0] s1(input logic [3:0] x);
        logic [3:0] idx;
        idx = {x[3], x[0], x[2], x[1]};
        return S1_T[{idx, 1'b0} +: 2];
    endfunction

    function automatic logic [4:0] rotl5(input logic [4:0] x, input int n);
        logic [4:0] y;
        y = x;
        for (int s = 0; s < 4; s++)
            if (s < n) y = {y[3:0], y[4]};
        return y;
    endfunction

endpackage

// File: rtl/sdes_round.sv
// One S-DES fk application on the permuted block, with swap unless last.
module sdes_round
    import sdes_pkg::*;
(
    input  logic [7:0] state,
    input  logic [7:0] subkey,
    input  logic       last,
    output logic [7:0] next
);

    logic [7:0] w_x;
    logic [3:0] w_f;
    logic [3:0] w_l;

    assign w_x  = ep(state[3:0]) ^ subkey;
    assign w_f  = p4({s0(w_x[7:4]), s1(w_x[3:0])});
    assign w_l  = state[7:4] ^ w_f;
    assign next = last ? {w_l, state[3:0]} : {state[3:0], w_l};

endmodule

// File: rtl/sdes_core.sv
// Iterative S-DES core, one round per cycle, valid/ready on both sides.
// Define SDES_CORE_DECRYPT_EN to honour in_mode (reverse subkey order).
module sdes_core
    import sdes_pkg::*;
#(
    parameter int NUM_ROUNDS = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       in_mode,
    input  logic [9:0] in_key,
    input  logic [7:0] in_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_data,
    output logic       busy
);

    localparam int CW = $clog2(NUM_ROUNDS + 1);

    state_e        r_state;
    state_e        w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_kidx;
    logic [7:0]    r_blk;
    logic [7:0]    r_out;
    logic          r_out_valid;
    logic [7:0]    r_subkey [NUM_ROUNDS];
    logic [7:0]    w_gen    [NUM_ROUNDS];
    logic [9:0]    w_p10;
    logic [7:0]    w_subkey;
    logic [7:0]    w_next;
    logic          w_last;
    logic          w_accept;

    assign in_ready  = rst_n && (r_state == IDLE);
    assign busy      = (r_state != IDLE);
    assign out_valid = r_out_valid;
    assign out_data  = r_out;
    assign w_accept  = in_valid && in_ready;
    assign w_last    = (r_cnt == CW'(NUM_ROUNDS - 1));
    assign w_p10     = p10(in_key);

    // Subkey i uses a cumulative rotation of 1 + 2*i positions
    always_comb begin
        for (int i = 0; i < NUM_ROUNDS; i++)
            w_gen[i] = p8({rotl5(w_p10[9:5], (1 + 2 * i) % 5),
                           rotl5(w_p10[4:0], (1 + 2 * i) % 5)});
    end

`ifdef SDES_CORE_DECRYPT_EN
    mode_e r_mode;

    always_ff @(posedge clk) begin
        if (!rst_n)
            r_mode <= ENC;
        else if (w_accept)
            r_mode <= mode_e'(in_mode);
    end

    assign w_kidx = (r_mode == DEC) ? CW'(NUM_ROUNDS - 1) - r_cnt : r_cnt;
`else
    logic w_unused_mode;
    assign w_unused_mode = in_mode;
    assign w_kidx        = r_cnt;
`endif

    always_comb begin
        w_subkey = '0;
        for (int i = 0; i < NUM_ROUNDS; i++)
            if (w_kidx == CW'(i)) w_subkey = r_subkey[i];
    end

    sdes_round u_round (
        .state  (r_blk),
        .subkey (w_subkey),
        .last   (w_last),
        .next   (w_next)
    );

    always_ff @(posedge clk) begin
        if (!rst_n)
            r_state <= IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE:    if (w_accept) w_state_nxt = ROUND;
            ROUND:   if (w_last) w_state_nxt = DONE;
            DONE:    if (r_out_valid && out_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // DONE spends its first cycle registering IIP into the output stage
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt       <= '0;
            r_blk       <= '0;
            r_out       <= '0;
            r_out_valid <= 1'b0;
            for (int i = 0; i < NUM_ROUNDS; i++)
                r_subkey[i] <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_blk <= ip(in_data);
                        r_cnt <= '0;
                        for (int i = 0; i < NUM_ROUNDS; i++)
                            r_subkey[i] <= w_gen[i];
                    end
                end
                ROUND: begin
                    r_blk <= w_next;
                    r_cnt <= r_cnt + CW'(1);
                end
                DONE: begin
                    if (!r_out_valid) begin
                        r_out_valid <= 1'b1;
                        r_out       <= iip(r_blk);
                    end else if (out_ready) begin
                        r_out_valid <= 1'b0;
                    end
                end
                default: r_out_valid <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_sdes_core.sv
// Directed and randomised checks of sdes_core at 2, 4 and 7 rounds.
module tb_sdes_core;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid  [3];
    logic       in_ready  [3];
    logic       in_mode   [3];
    logic [9:0] in_key    [3];
    logic [7:0] in_data   [3];
    logic       out_valid [3];
    logic       out_ready [3];
    logic [7:0] out_data  [3];
    logic       busy      [3];

    int checks = 0;
    int errors = 0;
    int nr_tab [3] = '{2, 4, 7};

    int P10_T [10] = '{3, 5, 2, 7, 4, 10, 1, 9, 8, 6};
    int P8_T  [8]  = '{6, 3, 7, 4, 8, 5, 10, 9};
    int IP_T  [8]  = '{2, 6, 3, 1, 4, 8, 5, 7};
    int IIP_T [8]  = '{4, 1, 3, 5, 7, 2, 8, 6};
    int EP_T  [8]  = '{4, 1, 2, 3, 2, 3, 4, 1};
    int P4_T  [4]  = '{2, 4, 3, 1};
    int S0_M [4][4] = '{'{1, 0, 3, 2}, '{3, 2, 1, 0}, '{0, 2, 1, 3}, '{3, 1, 3, 2}};
    int S1_M [4][4] = '{'{0, 1, 2, 3}, '{2, 0, 1, 3}, '{3, 0, 1, 0}, '{2, 1, 0, 3}};

    localparam logic [9:0] KEY0 = 10'b1010000010;
    localparam logic [7:0] PT0  = 8'b10010111;
    localparam logic [7:0] CT0  = 8'b00111000;

    always #5 clk = ~clk;

    sdes_core #(.NUM_ROUNDS(2)) u_r2 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_mode(in_mode[0]),
        .in_key(in_key[0]), .in_data(in_data[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .out_data(out_data[0]), .busy(busy[0])
    );

    sdes_core #(.NUM_ROUNDS(4)) u_r4 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_mode(in_mode[1]),
        .in_key(in_key[1]), .in_data(in_data[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .out_data(out_data[1]), .busy(busy[1])
    );

    sdes_core #(.NUM_ROUNDS(7)) u_r7 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[2]), .in_ready(in_ready[2]), .in_mode(in_mode[2]),
        .in_key(in_key[2]), .in_data(in_data[2]),
        .out_valid(out_valid[2]), .out_ready(out_ready[2]),
        .out_data(out_data[2]), .busy(busy[2])
    );

    // Table-driven reference: iterative key schedule, 1-based bit positions
    function automatic logic [7:0] model(input logic [9:0] key, input logic [7:0] din,
                                         input int n, input bit dec);
        logic [9:0] pk;
        logic [4:0] lh, rh;
        logic [7:0] sk [16];
        logic [7:0] b, e, y;
        logic [3:0] l, r, f, t;
        logic [3:0] tmp;
        int row, col, kk;
        for (int j = 0; j < 10; j++) pk[9-j] = key[10-P10_T[j]];
        lh = pk[9:5];
        rh = pk[4:0];
        for (int i = 0; i < n; i++) begin
            for (int s = 0; s < ((i == 0) ? 1 : 2); s++) begin
                lh = {lh[3:0], lh[4]};
                rh = {rh[3:0], rh[4]};
            end
            pk = {lh, rh};
            for (int j = 0; j < 8; j++) sk[i][7-j] = pk[10-P8_T[j]];
        end
        for (int j = 0; j < 8; j++) b[7-j] = din[8-IP_T[j]];
        l = b[7:4];
        r = b[3:0];
        for (int i = 0; i < n; i++) begin
            kk = dec ? (n - 1 - i) : i;
            for (int j = 0; j < 8; j++) e[7-j] = r[4-EP_T[j]];
            e = e ^ sk[kk];
            row = {e[7], e[4]};
            col = {e[6], e[5]};
            t[3:2] = 2'(S0_M[row][col]);
            row = {e[3], e[0]};
            col = {e[2], e[1]};
            t[1:0] = 2'(S1_M[row][col]);
            for (int j = 0; j < 4; j++) f[3-j] = t[4-P4_T[j]];
            l = l ^ f;
            if (i != n - 1) begin
                tmp = l;
                l = r;
                r = tmp;
            end
        end
        b = {l, r};
        for (int j = 0; j < 8; j++) y[7-j] = b[8-IIP_T[j]];
        return y;
    endfunction

    // Drives one request, measures edges from acceptance to out_valid (-1 on timeout)
    task automatic run_block(input int k, input logic mode, input logic [9:0] key,
                             input logic [7:0] d, output logic [7:0] res, output int lat);
        @(negedge clk);
        in_valid[k] = 1'b1;
        in_mode[k]  = mode;
        in_key[k]   = key;
        in_data[k]  = d;
        @(posedge clk);
        @(negedge clk);
        in_valid[k] = 1'b0;
        lat = -1;
        for (int e = 1; e <= 40; e++) begin
            if (e > 1 || out_valid[k] !== 1'b1) begin
                @(posedge clk);
                @(negedge clk);
            end
            if (out_valid[k] === 1'b1) begin
                lat = e;
                break;
            end
        end
        res = out_data[k];
        out_ready[k] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready[k] = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in_valid[k]  = 1'b0;
            in_mode[k]   = 1'b0;
            in_key[k]    = '0;
            in_data[k]   = '0;
            out_ready[k] = 1'b0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (in_ready[k] !== 1'b0) begin
                errors++;
                $display("FAIL reset_in_ready_low[%0d]: got %b want 0", k, in_ready[k]);
            end
        end
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (in_ready[k] !== 1'b1) begin
                errors++;
                $display("FAIL reset_in_ready[%0d]: got %b want 1", k, in_ready[k]);
            end
            checks++;
            if (out_valid[k] !== 1'b0) begin
                errors++;
                $display("FAIL reset_out_valid[%0d]: got %b want 0", k, out_valid[k]);
            end
            checks++;
            if (out_data[k] !== 8'h00) begin
                errors++;
                $display("FAIL reset_out_data[%0d]: got %h want 00", k, out_data[k]);
            end
            checks++;
            if (busy[k] !== 1'b0) begin
                errors++;
                $display("FAIL reset_busy[%0d]: got %b want 0", k, busy[k]);
            end
        end
    endtask

    task automatic test_known_vector;
        logic [7:0] res;
        int lat;
        run_block(0, 1'b0, KEY0, PT0, res, lat);
        checks++;
        if (res !== CT0) begin
            errors++;
            $display("FAIL known_enc: got %b want %b", res, CT0);
        end
        checks++;
        if (lat !== 3) begin
            errors++;
            $display("FAIL known_latency: got %0d want 3", lat);
        end
        checks++;
        if (u_r2.r_subkey[0] !== 8'b10100100) begin
            errors++;
            $display("FAIL known_k1: got %b want 10100100", u_r2.r_subkey[0]);
        end
        checks++;
        if (u_r2.r_subkey[1] !== 8'b01000011) begin
            errors++;
            $display("FAIL known_k2: got %b want 01000011", u_r2.r_subkey[1]);
        end
    endtask

    task automatic test_mode;
        logic [7:0] res;
        int lat;
`ifdef SDES_CORE_DECRYPT_EN
        run_block(0, 1'b1, KEY0, CT0, res, lat);
        checks++;
        if (res !== PT0) begin
            errors++;
            $display("FAIL known_dec: got %b want %b", res, PT0);
        end
`else
        run_block(0, 1'b1, KEY0, PT0, res, lat);
        checks++;
        if (res !== CT0) begin
            errors++;
            $display("FAIL mode_ignored: got %b want %b", res, CT0);
        end
`endif
        checks++;
        if (lat !== 3) begin
            errors++;
            $display("FAIL mode_latency: got %0d want 3", lat);
        end
    endtask

    task automatic test_backpressure;
        logic [7:0] exp;
        bit seen;
        exp = model(10'h2C7, 8'h5A, 2, 1'b0);
        @(negedge clk);
        in_valid[0] = 1'b1;
        in_mode[0]  = 1'b0;
        in_key[0]   = 10'h2C7;
        in_data[0]  = 8'h5A;
        @(posedge clk);
        @(negedge clk);
        in_valid[0] = 1'b0;
        seen = 1'b0;
        for (int e = 0; e < 20 && !seen; e++) begin
            @(posedge clk);
            @(negedge clk);
            seen = (out_valid[0] === 1'b1);
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL bp_out_valid_timeout: got 0 want 1");
        end
        in_valid[0] = 1'b1;
        in_data[0]  = 8'hFF;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (out_valid[0] !== 1'b1) begin
                errors++;
                $display("FAIL bp_hold_valid[%0d]: got %b want 1", c, out_valid[0]);
            end
            checks++;
            if (out_data[0] !== exp) begin
                errors++;
                $display("FAIL bp_hold_data[%0d]: got %h want %h", c, out_data[0], exp);
            end
            checks++;
            if (in_ready[0] !== 1'b0) begin
                errors++;
                $display("FAIL bp_in_ready[%0d]: got %b want 0", c, in_ready[0]);
            end
        end
        in_valid[0]  = 1'b0;
        out_ready[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready[0] = 1'b0;
        checks++;
        if (in_ready[0] !== 1'b1 || out_valid[0] !== 1'b0 || busy[0] !== 1'b0) begin
            errors++;
            $display("FAIL bp_release: got rdy=%b vld=%b busy=%b want 1 0 0",
                     in_ready[0], out_valid[0], busy[0]);
        end
        checks++;
        if (out_data[0] !== exp) begin
            errors++;
            $display("FAIL bp_retain_data: got %h want %h", out_data[0], exp);
        end
        repeat (6) @(posedge clk);
        @(negedge clk);
        checks++;
        if (out_valid[0] !== 1'b0 || busy[0] !== 1'b0) begin
            errors++;
            $display("FAIL bp_ignored_req: got vld=%b busy=%b want 0 0",
                     out_valid[0], busy[0]);
        end
    endtask

    task automatic test_reset_mid;
        logic [7:0] res;
        int lat;
        @(negedge clk);
        in_valid[0] = 1'b1;
        in_mode[0]  = 1'b0;
        in_key[0]   = 10'h155;
        in_data[0]  = 8'hC3;
        @(posedge clk);
        @(negedge clk);
        in_valid[0] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (busy[0] !== 1'b1) begin
            errors++;
            $display("FAIL mid_busy_before: got %b want 1", busy[0]);
        end
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (out_valid[0] !== 1'b0 || out_data[0] !== 8'h00 || busy[0] !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: got vld=%b data=%h busy=%b want 0 00 0",
                     out_valid[0], out_data[0], busy[0]);
        end
        checks++;
        if (in_ready[0] !== 1'b0) begin
            errors++;
            $display("FAIL mid_in_ready: got %b want 0", in_ready[0]);
        end
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        checks++;
        if (out_valid[0] !== 1'b0 || in_ready[0] !== 1'b1) begin
            errors++;
            $display("FAIL mid_no_output: got vld=%b rdy=%b want 0 1",
                     out_valid[0], in_ready[0]);
        end
        run_block(0, 1'b0, KEY0, PT0, res, lat);
        checks++;
        if (res !== CT0 || lat !== 3) begin
            errors++;
            $display("FAIL mid_fresh: got %b lat %0d want %b lat 3", res, lat, CT0);
        end
    endtask

    task automatic test_random;
        logic [9:0] key;
        logic [7:0] d, exp, res, res2;
        int lat, lat2;
        for (int k = 1; k < 3; k++) begin
            for (int it = 0; it < 256; it++) begin
                key = 10'($urandom_range(0, 1023));
                d   = 8'($urandom_range(0, 255));
                exp = model(key, d, nr_tab[k], 1'b0);
                run_block(k, 1'b0, key, d, res, lat);
                checks++;
                if (res !== exp) begin
                    errors++;
                    $display("FAIL rand_enc r%0d key=%h d=%h: got %h want %h",
                             nr_tab[k], key, d, res, exp);
                end
                checks++;
                if (lat !== nr_tab[k] + 1) begin
                    errors++;
                    $display("FAIL rand_latency r%0d: got %0d want %0d",
                             nr_tab[k], lat, nr_tab[k] + 1);
                end
`ifdef SDES_CORE_DECRYPT_EN
                run_block(k, 1'b1, key, res, res2, lat2);
                checks++;
                if (res2 !== d) begin
                    errors++;
                    $display("FAIL rand_dec r%0d key=%h c=%h: got %h want %h",
                             nr_tab[k], key, res, res2, d);
                end
`else
                run_block(k, 1'b1, key, d, res2, lat2);
                checks++;
                if (res2 !== exp) begin
                    errors++;
                    $display("FAIL rand_mode_ignored r%0d: got %h want %h",
                             nr_tab[k], res2, exp);
                end
`endif
                checks++;
                if (lat2 !== nr_tab[k] + 1) begin
                    errors++;
                    $display("FAIL rand_latency2 r%0d: got %0d want %0d",
                             nr_tab[k], lat2, nr_tab[k] + 1);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_known_vector();
        test_mode();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
